// File: rtl/dsd_decim_fifo.sv
// Decimating output FIFO behind the moving-average filter.
// Keeps one of every DECIM valid samples and counts samples dropped while the FIFO is full.
module dsd_decim_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int DECIM      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          valid_i,
    output logic [DATA_WIDTH-1:0]         m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic [CNT_WIDTH-1:0]          drop_cnt_o,
    input  logic                          clr_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PW-1:0]         phase_q, phase_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

    logic keep;
    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    assign m_valid_o  = (level_q != '0);
    assign m_data_o   = m_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

    always_comb begin
        keep  = valid_i && (phase_q == '0);
        pop   = m_valid_o && m_ready_i;
        full  = (level_q == LW'(FIFO_DEPTH));
        wr_en = keep && (!full || pop);
        drop  = keep && full && !pop;
    end

    always_comb begin
        phase_d  = phase_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;
        if (valid_i) begin
            phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
        end
        if (wr_en) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // A drop coinciding with a clear restarts the count at one.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_i) begin
                drop_cnt_d = CNT_WIDTH'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end else if (clr_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_dsd_decim_fifo.sv
// Directed bench for dsd_decim_fifo.
// Three instances cover DECIM = 4, 1 and 3 with shared stimulus.
module tb_dsd_decim_fifo;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        clr;

    logic [31:0] md4, md1, md3;
    logic        mv4, mv1, mv3;
    logic [3:0]  lv4, lv1, lv3;
    logic        ov4, ov1, ov3;
    logic [15:0] dc4, dc1, dc3;

    int tests_run;
    int tests_failed;

    dsd_decim_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .DECIM(4), .CNT_WIDTH(16)) u_d4 (
        .clk(clk), .rst_n(rst_n), .data_i(data), .valid_i(valid),
        .m_data_o(md4), .m_valid_o(mv4), .m_ready_i(ready),
        .level_o(lv4), .overflow_o(ov4), .drop_cnt_o(dc4), .clr_i(clr)
    );

    dsd_decim_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .DECIM(1), .CNT_WIDTH(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .data_i(data), .valid_i(valid),
        .m_data_o(md1), .m_valid_o(mv1), .m_ready_i(ready),
        .level_o(lv1), .overflow_o(ov1), .drop_cnt_o(dc1), .clr_i(clr)
    );

    dsd_decim_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .DECIM(3), .CNT_WIDTH(16)) u_d3 (
        .clk(clk), .rst_n(rst_n), .data_i(data), .valid_i(valid),
        .m_data_o(md3), .m_valid_o(mv3), .m_ready_i(ready),
        .level_o(lv3), .overflow_o(ov3), .drop_cnt_o(dc3), .clr_i(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [31:0] d);
        data  = d;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        int vp [7];
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        data  = '0;
        valid = 1'b0;
        ready = 1'b0;
        clr   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_level", lv4, 0);
        chk("rst_valid", mv4, 0);
        chk("rst_data", md4, 0);
        chk("rst_ovf", ov4, 0);
        chk("rst_cnt", dc4, 0);

        // DECIM=4 streaming with an always-ready sink
        ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            data  = i;
            valid = 1'b1;
            tick();
            chk($sformatf("d4_valid_%0d", i), mv4, (i % 4 == 1));
            if (i % 4 == 1) chk($sformatf("d4_data_%0d", i), md4, i);
            chk($sformatf("d4_lvl_%0d", i), (lv4 > 1), 0);
        end
        valid = 1'b0;
        tick();
        chk("d4_drained", mv4, 0);

        // DECIM=1 overflow, drain, full-with-pop, clear
        do_reset();
        ready = 1'b0;
        for (int i = 1; i <= 10; i++) push(i);
        chk("d1_full_lvl", lv1, 8);
        chk("d1_full_ovf", ov1, 1);
        chk("d1_full_cnt", dc1, 2);
        ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            chk($sformatf("d1_out_%0d", j), md1, j);
            tick();
        end
        ready = 1'b0;
        chk("d1_empty_valid", mv1, 0);
        chk("d1_empty_data", md1, 0);
        chk("d1_empty_lvl", lv1, 0);

        for (int i = 21; i <= 28; i++) push(i);
        chk("d1_refill_lvl", lv1, 8);
        ready = 1'b1;
        push(29);
        ready = 1'b0;
        chk("d1_popwr_lvl", lv1, 8);
        chk("d1_popwr_cnt", dc1, 2);
        ready = 1'b1;
        for (int j = 22; j <= 29; j++) begin
            chk($sformatf("d1_out2_%0d", j), md1, j);
            tick();
        end
        ready = 1'b0;
        chk("d1_empty2", mv1, 0);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("d1_clr_ovf", ov1, 0);
        chk("d1_clr_cnt", dc1, 0);
        for (int i = 0; i < 15; i++) push(40 + i);
        chk("d1_cnt7", dc1, 7);
        chk("d1_cnt7_ovf", ov1, 1);
        clr = 1'b1;
        push(60);
        clr = 1'b0;
        chk("d1_clrdrop_ovf", ov1, 1);
        chk("d1_clrdrop_cnt", dc1, 1);

        // DECIM=3 with gaps in valid_i
        do_reset();
        ready = 1'b0;
        vp = '{1, 0, 0, 1, 1, 0, 1};
        for (int i = 0; i < 7; i++) begin
            data  = 10 + i;
            valid = (vp[i] != 0);
            tick();
        end
        valid = 1'b0;
        chk("d3_lvl", lv3, 2);
        ready = 1'b1;
        chk("d3_out0", md3, 10);
        tick();
        chk("d3_out1", md3, 16);
        tick();
        chk("d3_empty", mv3, 0);
        ready = 1'b0;

        // Reset mid-stream with phase off zero
        do_reset();
        for (int i = 0; i < 14; i++) push(100 + i);
        chk("d3_lvl5", lv3, 5);
        do_reset();
        chk("mid_rst_lvl", lv3, 0);
        chk("mid_rst_valid", mv3, 0);
        chk("mid_rst_data", md3, 0);
        push(77);
        chk("post_rst_lvl", lv3, 1);
        chk("post_rst_data", md3, 77);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
